// File: rtl/voice_note_driver_pkg.sv
// Shared definitions for the voice note driver: FSM states, semitone constant
// and the top-octave phase-increment table (notes 84..95) for a given clock rate.
package voice_note_driver_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, RETRIG} state_t;

  localparam int unsigned SEMITONES = 12;

  typedef logic [31:0] freq_table_t [SEMITONES];

  // Note frequencies in micro-hertz for MIDI notes 84 (C6) .. 95 (B6)
  localparam longint unsigned NOTE_UHZ [SEMITONES] = '{
    64'd1046502261, 64'd1108730524, 64'd1174659072, 64'd1244507935,
    64'd1318510228, 64'd1396912926, 64'd1479977691, 64'd1567981744,
    64'd1661218790, 64'd1760000000, 64'd1864655046, 64'd1975533205
  };

  // FREQ_TABLE[i] = round(f_i * 2^24 / clk_hz)
  function automatic freq_table_t build_freq_table(input longint unsigned clk_hz);
    freq_table_t t;
    for (int unsigned i = 0; i < SEMITONES; i++) begin
      t[i] = 32'((NOTE_UHZ[i] * 64'd16777216 + clk_hz * 64'd500000) / (clk_hz * 64'd1000000));
    end
    return t;
  endfunction

endpackage

// File: rtl/note_to_freq.sv
// Maps a semitone remainder and octave to a phase increment, scaling the
// top-octave table entry down or up and saturating to all-ones on overflow.
module note_to_freq
  import voice_note_driver_pkg::*;
#(
  parameter int unsigned FREQ_BITS = 16,
  parameter int unsigned CLK_HZ    = 1000000
) (
  input  logic [3:0]           remainder,
  input  logic [3:0]           octave,
  output logic [FREQ_BITS-1:0] freq
);

  localparam freq_table_t FREQ_TABLE = build_freq_table(64'(CLK_HZ));

  // Wide enough for a 32-bit entry shifted left by up to 8 octaves
  logic [FREQ_BITS+39:0] base;
  logic [FREQ_BITS+39:0] scaled;

  always_comb begin
    base = '0;
    base[31:0] = FREQ_TABLE[remainder];
    if (octave <= 4'd7) begin
      scaled = base >> (4'd7 - octave);
    end else begin
      scaled = base << (octave - 4'd7);
    end
    freq = (|(scaled >> FREQ_BITS)) ? '1 : scaled[FREQ_BITS-1:0];
  end

endmodule

// File: rtl/voice_note_driver.sv
// Single-voice note event sequencer: accepts note-on/off events, converts the
// note number to a phase increment and drives the envelope gate with retrigger.
module voice_note_driver
  import voice_note_driver_pkg::*;
#(
  parameter int unsigned FREQ_BITS     = 16,
  parameter int unsigned RETRIG_CYCLES = 64,
  parameter int unsigned CLK_HZ        = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 note_valid,
  output logic                 note_ready,
  input  logic                 note_on,
  input  logic [6:0]           note_num,
  input  logic                 all_off,
  output logic [FREQ_BITS-1:0] tone_freq,
  output logic                 gate,
  output logic [6:0]           active_note
);

  localparam int unsigned CW = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;

  state_t               state, state_next;
  logic [6:0]           remainder;
  logic [3:0]           octave;
  logic [6:0]           note_q;
  logic [CW-1:0]        retrig_cnt;
  logic [FREQ_BITS-1:0] freq;
  logic                 gate_next;
  logic                 start, step, load;

  note_to_freq #(
    .FREQ_BITS (FREQ_BITS),
    .CLK_HZ    (CLK_HZ)
  ) u_note_to_freq (
    .remainder (remainder[3:0]),
    .octave    (octave),
    .freq      (freq)
  );

  assign note_ready = (state == IDLE) && !all_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gate_next  = gate;
    start      = 1'b0;
    step       = 1'b0;
    load       = 1'b0;
    if (all_off) begin
      state_next = IDLE;
      gate_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (note_valid) begin
            if (note_on) begin
              start      = 1'b1;
              state_next = CONVERT;
            end else if (gate && note_num == active_note) begin
              gate_next = 1'b0;
            end
          end
        end
        CONVERT: begin
          if (remainder >= 7'(SEMITONES)) begin
            step = 1'b1;
          end else if (!gate) begin
            load       = 1'b1;
            gate_next  = 1'b1;
            state_next = IDLE;
          end else begin
            gate_next  = 1'b0;
            state_next = RETRIG;
          end
        end
        RETRIG: begin
          if (retrig_cnt == CW'(RETRIG_CYCLES - 1)) begin
            load       = 1'b1;
            gate_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remainder   <= '0;
      octave      <= '0;
      note_q      <= '0;
      retrig_cnt  <= '0;
      gate        <= 1'b0;
      tone_freq   <= '0;
      active_note <= '0;
    end else begin
      gate <= gate_next;
      if (start) begin
        remainder <= note_num;
        octave    <= '0;
        note_q    <= note_num;
      end else if (step) begin
        remainder <= remainder - 7'(SEMITONES);
        octave    <= octave + 4'd1;
      end
      // Counter only advances while the RETRIG state survives the edge
      retrig_cnt <= (state == RETRIG && state_next == RETRIG) ? retrig_cnt + CW'(1) : '0;
      if (load) begin
        tone_freq   <= freq;
        active_note <= note_q;
      end
    end
  end

endmodule

// File: tb/tb_voice_note_driver.sv
// Scoreboard bench for voice_note_driver: expected note-on results are queued
// at accept time and popped when the gate rises.
module tb_voice_note_driver;

  localparam int unsigned FREQ_BITS     = 16;
  localparam int unsigned RETRIG_CYCLES = 64;
  localparam int unsigned CLK_HZ        = 1000000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 note_valid = 1'b0;
  logic                 note_ready;
  logic                 note_on = 1'b0;
  logic [6:0]           note_num = '0;
  logic                 all_off = 1'b0;
  logic [FREQ_BITS-1:0] tone_freq;
  logic                 gate;
  logic [6:0]           active_note;

  voice_note_driver #(
    .FREQ_BITS     (FREQ_BITS),
    .RETRIG_CYCLES (RETRIG_CYCLES),
    .CLK_HZ        (CLK_HZ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_on     (note_on),
    .note_num    (note_num),
    .all_off     (all_off),
    .tone_freq   (tone_freq),
    .gate        (gate),
    .active_note (active_note)
  );

  always #5 clk = ~clk;

  typedef struct {
    int note;
    int freq;
    int conv;
    bit retrig;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_gate = 1'b0;
  int   m_active = 0;
  int   m_freq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_freq(input int n);
    int     oct = n / 12;
    int     r = n % 12;
    real    f;
    longint base, v;
    f = 440.0 * $pow(2.0, real'(84 + r - 69) / 12.0);
    base = longint'($rtoi(f * 16777216.0 / real'(CLK_HZ) + 0.5));
    v = (oct <= 7) ? (base >> (7 - oct)) : (base << (oct - 7));
    if (v > 65535) v = 65535;
    return int'(v);
  endfunction

  // Handshake only; returns 1 ns after the accept edge
  task automatic offer(input bit on, input int num);
    int n = 0;
    while (!note_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 300), 32'd1);
    note_valid = 1'b1;
    note_on    = on;
    note_num   = 7'(num);
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  task automatic await_voice();
    exp_t e;
    int   c = 0;
    bit   ready_seen = 1'b0;
    e = sb.pop_front();
    if (!e.retrig) begin
      while (!gate && c < 50) begin
        @(posedge clk);
        #1 c++;
      end
      check("conv_len", 32'(c), 32'(e.conv));
    end else begin
      while (gate && c < 50) begin
        @(posedge clk);
        #1 c++;
      end
      check("retrig_conv_len", 32'(c), 32'(e.conv));
      c = 0;
      while (!gate && c < 200) begin
        if (note_ready) ready_seen = 1'b1;
        @(posedge clk);
        #1 c++;
      end
      check("retrig_len", 32'(c), 32'(RETRIG_CYCLES));
      check("retrig_ready_low", 32'(ready_seen), 32'd0);
    end
    check("gate_on", 32'(gate), 32'd1);
    check("tone_freq", 32'(tone_freq), 32'(e.freq));
    check("active_note", 32'(active_note), 32'(e.note));
    m_gate = 1'b1;
    m_active = e.note;
    m_freq = e.freq;
  endtask

  task automatic play(input int num);
    exp_t e;
    e.note = num;
    e.freq = exp_freq(num);
    e.conv = num / 12 + 1;
    e.retrig = m_gate;
    sb.push_back(e);
    offer(1'b1, num);
    await_voice();
  endtask

  task automatic release_note(input int num);
    offer(1'b0, num);
    if (m_gate && num == m_active) m_gate = 1'b0;
    check("off_gate", 32'(gate), 32'(m_gate));
    check("off_freq", 32'(tone_freq), 32'(m_freq));
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    bit rose = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (gate) rose = 1'b1;
    end
    check(tag, 32'(rose), 32'd0);
  endtask

  initial begin
    int extra[5] = '{12, 35, 95, 100, 48};
    int c;

    repeat (2) @(posedge clk);
    #1;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_freq", 32'(tone_freq), 32'd0);
    check("rst_active", 32'(active_note), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_ready", 32'(note_ready), 32'd1);

    play(69);
    check("freq69_const", 32'(tone_freq), 32'd7382);
    release_note(69);
    play(0);
    check("freq0_const", 32'(tone_freq), 32'd137);
    release_note(0);
    play(127);
    check("freq127_sat", 32'(tone_freq), 32'hFFFF);
    release_note(127);

    foreach (extra[i]) begin
      play(extra[i]);
      release_note(extra[i]);
    end

    play(60);
    release_note(62);
    release_note(60);
    play(60);
    play(64);

    // all_off in the middle of a retrigger
    offer(1'b1, 72);
    c = 0;
    while (gate && c < 50) begin
      @(posedge clk);
      #1 c++;
    end
    repeat (10) @(posedge clk);
    @(negedge clk) all_off = 1'b1;
    #1 check("alloff_ready", 32'(note_ready), 32'd0);
    @(posedge clk);
    #1 all_off = 1'b0;
    m_gate = 1'b0;
    check("alloff_gate", 32'(gate), 32'd0);
    check("alloff_freq", 32'(tone_freq), 32'(m_freq));
    check("alloff_active", 32'(active_note), 32'(m_active));
    quiet_window("alloff_no_resume", 80);
    check("alloff_ready_after", 32'(note_ready), 32'd1);

    // all_off on the same edge as a note-on offer
    @(negedge clk);
    note_valid = 1'b1;
    note_on    = 1'b1;
    note_num   = 7'd50;
    all_off    = 1'b1;
    #1 check("same_edge_ready", 32'(note_ready), 32'd0);
    @(posedge clk);
    #1 begin
      note_valid = 1'b0;
      all_off    = 1'b0;
    end
    quiet_window("same_edge_no_accept", 20);
    check("same_edge_active", 32'(active_note), 32'(m_active));
    check("same_edge_freq", 32'(tone_freq), 32'(m_freq));

    // asynchronous reset in the middle of a conversion
    offer(1'b1, 127);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_freq", 32'(tone_freq), 32'd0);
    check("async_rst_active", 32'(active_note), 32'd0);
    check("async_rst_gate", 32'(gate), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("async_rst_ready", 32'(note_ready), 32'd1);
    m_gate = 1'b0;
    m_active = 0;
    m_freq = 0;
    quiet_window("async_rst_no_update", 30);
    check("async_rst_freq_hold", 32'(tone_freq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_note_driver.md
VOICE_NOTE_DRIVER -- requirements
Module: voice_note_driver

Interface
REQ-001 Parameter FREQ_BITS, default 16, width of tone_freq (matches the voice frequency input).
REQ-002 Parameter RETRIG_CYCLES, default 64, forced gate-low cycles before a retriggered note-on.
REQ-003 Parameter CLK_HZ, default 1000000, voice clock rate used to build the frequency table.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 note_valid  input  1  note event offered.
REQ-007 note_ready  output  1  event accepted when note_valid and note_ready are high at a rising edge.
REQ-008 note_on  input  1  1 = note-on, 0 = note-off; qualified by note_valid.
REQ-009 note_num  input  7  MIDI note number 0..127; qualified by note_valid.
REQ-010 all_off  input  1  synchronous panic: gate off, abort any event in progress.
REQ-011 tone_freq  output  FREQ_BITS  registered phase increment for the voice.
REQ-012 gate  output  1  registered envelope gate for the voice.
REQ-013 active_note  output  7  registered note number of the last note-on applied.

Function
REQ-014 The FSM SHALL have states IDLE, CONVERT and RETRIG; note_ready SHALL equal (state==IDLE && !all_off).
REQ-015 Note-on accept: latch note_num, clear octave counter, go to CONVERT.
REQ-016 CONVERT: each cycle, if remainder >= 12, subtract 12 and increment octave; otherwise finish; CONVERT SHALL last octave+1 cycles (1..11).
REQ-017 Frequency: base = FREQ_TABLE[remainder], the entries for notes 84..95; for octave <= 7, tone_freq = base >> (7-octave); for octave > 7, tone_freq = base << (octave-7), saturated to all-ones on overflow.
REQ-018 On CONVERT finish with gate low: update tone_freq and active_note, set gate=1, return to IDLE on the same edge.
REQ-019 On CONVERT finish with gate high: drive gate=0 and enter RETRIG; hold for RETRIG_CYCLES cycles; then update tone_freq and active_note, set gate=1 and return to IDLE.
REQ-020 Note-off accept with gate=1 and note_num==active_note: gate=0 on the next edge; tone_freq unchanged; state stays IDLE.
REQ-021 Note-off for any other note, or with gate=0: SHALL be accepted and ignored.
REQ-022 all_off high at an edge: gate=0, state=IDLE, discard any pending conversion; tone_freq and active_note unchanged; all_off takes priority over every other event.
REQ-023 Events arriving while note_ready=0 SHALL be held by the sender and never dropped or duplicated by this block.

Reset
REQ-024 While rst is high: state=IDLE, gate=0, tone_freq=0, active_note=0, octave and retrigger counters=0; note_ready SHALL be 1 once rst falls.
REQ-025 Reset asserted mid-CONVERT or mid-RETRIG SHALL abort the event with no output update.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the 12-entry FREQ_TABLE of round(f*2^24/CLK_HZ) for notes 84..95, and the constant 12.
REQ-027 Conversion (remainder/octave to tone_freq, including saturation) SHALL be one sub-module, note_to_freq; sequencing stays in voice_note_driver.

Verification
REQ-028 Reset then note-on 69 with gate low -> gate rises 6 cycles after the accept edge; tone_freq=7382 (29528>>2); active_note=69.
REQ-029 Note-on 0 -> tone_freq=137; note-on 127 -> tone_freq saturates to 0xFFFF; CONVERT lengths of 1 and 11 cycles respectively.
REQ-030 Note 60 playing, then note-on 64 -> gate low for exactly 64 cycles after CONVERT, then gate=1 and active_note=64; note_ready low throughout.
REQ-031 Note 60 playing, note-off 62 -> gate stays 1; note-off 60 -> gate=0 next edge, tone_freq unchanged.
REQ-032 all_off asserted during RETRIG, and also on the same edge as note_valid -> gate=0, IDLE, no accept, tone_freq and active_note unchanged.
REQ-033 rst pulsed mid-CONVERT -> all outputs return to reset values immediately (asynchronously), note_ready=1 after release.
